fat_reduce_pipe: RTL and testbench
==================================

// Module: fat_reduce_pipe
// PURPOSE
//   Parametrised, pipelined radix-4 fan-in reduction tree. Collapses a WIDTH-bit
//   vector to one bit per cycle, using a per-word mode of OR, AND or XOR.
//   Adds valid tracking, a sticky hit flag and a saturating hit counter.
//   Sits after the error/flag collection logic, feeding the event monitor.
// PARAMETERS
//   WIDTH    32  input vector width, 4..256; need not be a power of 4
//   COUNT_W  16  hit_count width, 1..32
//   (derived) LEVELS = ceil(log4(WIDTH)), minimum 1; LAT = LEVELS+1 (WIDTH=32: LEVELS=3, LAT=4)
// PORTS
//   clk         in   1        clock; all state updates on the rising edge
//   rst         in   1        synchronous reset, active-high
//   in_valid    in   1        in_data/in_mode valid this cycle
//   in_mode     in   2        00=OR, 01=AND, 10=XOR, 11=reserved (treated as OR)
//   in_data     in   WIDTH    vector to reduce
//   clear       in   1        clears sticky_hit and hit_count
//   out_valid   out  1        out_result/out_mode valid
//   out_result  out  1        reduced bit; 0 whenever out_valid=0
//   out_mode    out  2        mode of the word on the output; 00 whenever out_valid=0
//   sticky_hit  out  1        set by any out_valid && out_result; cleared by clear
//   hit_count   out  COUNT_W  count of out_valid && out_result, saturating
// BEHAVIOUR
//   - Reset: all pipeline valid bits = 0; out_valid, out_result, out_mode, sticky_hit = 0; hit_count = 0.
//     in_valid is ignored while rst=1. Reset mid-stream discards all in-flight words; no output afterwards.
//   - Stage 0 registers in_data, in_mode and in_valid.
//   - Padding to 4^LEVELS bits uses the identity for the word's mode: OR/XOR pad 0, AND pad 1.
//   - Each tree level combines groups of 4 bits (OR4 / AND4 / XOR4) and is registered.
//     Mode and valid travel with the data.
//   - Mode 11 behaves exactly as 00.
//   - Latency: a word with in_valid=1 at edge N appears with out_valid=1 after edge N+LAT.
//   - Throughput: one word per cycle; no backpressure. Back-to-back words with mixed modes
//     must not interact.
//   - Bubbles (in_valid=0) propagate as out_valid=0. Data registers may load freely,
//     but out_result and out_mode are forced to 0 when invalid.
//   - hit event h = out_valid && out_result (registered outputs).
//   - sticky_hit: next = h | (sticky_hit & ~clear). Simultaneous clear and h leaves 1.
//   - hit_count: next = clear ? (h ? 1 : 0) : (h && hit_count != all-ones ? hit_count+1 : hit_count).
//     Saturates at 2^COUNT_W-1 and never wraps.
//   - sticky_hit and hit_count update the cycle after the out_valid cycle that carries the hit.
//   - clear and rst have no effect on pipeline data; rst has priority over clear.
// TESTING
//   1 OR: in_data=32'h0000_0100, mode 00, single valid -> out_valid=1, out_result=1
//     exactly 4 cycles later; sticky_hit=1, hit_count=1 one cycle after that.
//   2 AND/XOR: 32'hFFFF_FFFF mode 01 -> 1; 32'hFFFF_FFFE mode 01 -> 0; 32'h0000_0007 mode 10 -> 1;
//     32'h0000_0003 mode 10 -> 0; sent back-to-back, results in order on consecutive cycles.
//   3 Padding: WIDTH=20, LEVELS=3, LAT=4. 20'hFFFFF mode 01 -> 1; 20'h00000 mode 00 -> 0;
//     20'h80000 mode 10 -> 1.
//   4 Bubbles/mode 11: pattern valid,0,valid with 32'h1 mode 11 -> out_valid 1,0,1 with result 1;
//     out_result=0 in the gap.
//   5 Counter: COUNT_W=2, five hits -> hit_count 1,2,3,3,3. clear asserted on the cycle of a
//     sixth hit -> hit_count=1, sticky_hit=1.
//   6 Reset mid-flight: 3 valid words, rst pulsed one cycle after the last -> no out_valid
//     afterwards; all outputs 0.

Source files
------------

// File: rtl/fat_reduce_pipe_if.sv
// Bus bundle for fat_reduce_pipe: input word stream, clear strobe and the
// registered result/hit outputs.
// Handshake: valid-only. A word transfers on every rising edge where in_valid=1.
// There is no ready signal, so the sink must accept one word per cycle.
// out_valid marks a result word and never stalls.
interface fat_reduce_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic [1:0]         in_mode;
  logic [WIDTH-1:0]   in_data;
  logic               clear;
  logic               out_valid;
  logic               out_result;
  logic [1:0]         out_mode;
  logic               sticky_hit;
  logic [COUNT_W-1:0] hit_count;

  // Driver side (the flag collection logic, or the testbench).
  modport master (
    output in_valid, in_mode, in_data, clear,
    input  out_valid, out_result, out_mode, sticky_hit, hit_count
  );

  // Reduction tree side.
  modport slave (
    input  in_valid, in_mode, in_data, clear,
    output out_valid, out_result, out_mode, sticky_hit, hit_count
  );
endinterface

// File: rtl/fat_reduce_pipe.sv
// Pipelined radix-4 reduction tree (OR / AND / XOR per word), with valid tracking,
// a sticky hit flag and a saturating hit counter.
// Pipeline layout: stage 0 holds the padded input word. Tree levels 1..LEVELS each
// reduce groups of 4 bits. An output register forces result and mode to 0 on
// bubbles. All tree levels share one flat register r_tree. Level l starts at
// bit f_off(l) and is PW>>(2*l) bits wide.
module fat_reduce_pipe #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  fat_reduce_pipe_if.slave bus
);

  // Number of radix-4 levels needed to cover WIDTH bits (at least 1).
  function automatic int f_levels(input int w);
    int l;
    int c;
    l = 1;
    c = 4;
    while (c < w) begin
      c = c * 4;
      l = l + 1;
    end
    return l;
  endfunction

  localparam int LEVELS = f_levels(WIDTH);
  localparam int PW     = 1 << (2 * LEVELS);

  // Bit offset of level l inside the flat tree register.
  function automatic int f_off(input int l);
    int o;
    o = 0;
    for (int k = 0; k < l; k++) o = o + (PW >> (2 * k));
    return o;
  endfunction

  localparam int TOT = f_off(LEVELS + 1);

  // One radix-4 reduction. Mode 11 falls into the OR default.
  function automatic logic f_red(input logic [3:0] b, input logic [1:0] m);
    logic r;
    case (m)
      2'b01:   r = &b;
      2'b10:   r = ^b;
      default: r = |b;
    endcase
    return r;
  endfunction

  logic [TOT-1:0]       r_tree;
  logic [LEVELS:0]      r_valid;
  logic [LEVELS:0][1:0] r_mode;
  logic [PW-1:0]        w_pad_data;
  logic                 w_hit;

  logic                 r_out_valid;
  logic                 r_out_result;
  logic [1:0]           r_out_mode;
  logic                 r_sticky;
  logic [COUNT_W-1:0]   r_count;

  // Pad the input to PW bits with the identity of its mode (1 for AND, else 0).
  always_comb begin
    w_pad_data              = {PW{(bus.in_mode == 2'b01)}};
    w_pad_data[WIDTH-1:0]   = bus.in_data;
  end

  // Data and mode path: loads every cycle, with no reset, because valid gates everything.
  always_ff @(posedge clk) begin
    r_tree[PW-1:0] <= w_pad_data;
    r_mode         <= {r_mode[LEVELS-1:0], bus.in_mode};
    for (int l = 1; l <= LEVELS; l++) begin
      for (int j = 0; j < (PW >> (2 * l)); j++) begin
        r_tree[f_off(l) + j] <= f_red(r_tree[f_off(l - 1) + 4 * j +: 4], r_mode[l - 1]);
      end
    end
  end

  // Valid shift chain. Reset flushes all in-flight words.
  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else     r_valid <= {r_valid[LEVELS-1:0], bus.in_valid};
  end

  // Output register: result and mode are forced to 0 when the word is a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 1'b0;
      r_out_mode   <= 2'b00;
    end else begin
      r_out_valid  <= r_valid[LEVELS];
      r_out_result <= r_valid[LEVELS] & r_tree[TOT-1];
      r_out_mode   <= r_valid[LEVELS] ? r_mode[LEVELS] : 2'b00;
    end
  end

  assign w_hit = r_out_valid & r_out_result;

  // Sticky hit flag and saturating counter. A hit in the same cycle as clear still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else begin
      r_sticky <= w_hit | (r_sticky & ~bus.clear);
      if (bus.clear)                    r_count <= w_hit ? COUNT_W'(1) : '0;
      else if (w_hit && r_count != '1)  r_count <= r_count + COUNT_W'(1);
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_mode   = r_out_mode;
  assign bus.sticky_hit = r_sticky;
  assign bus.hit_count  = r_count;

endmodule

// File: tb/tb_fat_reduce_pipe.sv
// Directed bench for fat_reduce_pipe. There are three instances:
//   a: WIDTH 32 / COUNT_W 16 for the main function, bubbles, clear and reset;
//   b: WIDTH 20 / COUNT_W 16 for identity padding;
//   c: WIDTH 32 / COUNT_W 2 for counter saturation.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
// A word driven in loop iteration k shows up at iteration k+5, which is LAT=4 edges
// after its capture edge.
module tb_fat_reduce_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fat_reduce_pipe_if #(.WIDTH(32), .COUNT_W(16)) ifa ();
  fat_reduce_pipe_if #(.WIDTH(20), .COUNT_W(16)) ifb ();
  fat_reduce_pipe_if #(.WIDTH(32), .COUNT_W(2))  ifc ();

  fat_reduce_pipe #(.WIDTH(32), .COUNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  fat_reduce_pipe #(.WIDTH(20), .COUNT_W(16)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  fat_reduce_pipe #(.WIDTH(32), .COUNT_W(2))  u_c (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic        v;
    logic [31:0] data;
    logic [1:0]  mode;
    logic        exp;
  } vec_t;

  vec_t tab[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [31:0] d, input logic [1:0] m);
    case (sel)
      0: begin ifa.in_valid = v; ifa.in_data = d;       ifa.in_mode = m; end
      1: begin ifb.in_valid = v; ifb.in_data = d[19:0]; ifb.in_mode = m; end
      default: begin ifc.in_valid = v; ifc.in_data = d; ifc.in_mode = m; end
    endcase
  endtask

  task automatic get_out(input int sel, output logic v, output logic r, output logic [1:0] m,
                         output logic s, output logic [15:0] c);
    case (sel)
      0: begin v = ifa.out_valid; r = ifa.out_result; m = ifa.out_mode; s = ifa.sticky_hit; c = ifa.hit_count; end
      1: begin v = ifb.out_valid; r = ifb.out_result; m = ifb.out_mode; s = ifb.sticky_hit; c = ifb.hit_count; end
      default: begin v = ifc.out_valid; r = ifc.out_result; m = ifc.out_mode; s = ifc.sticky_hit; c = 16'(ifc.hit_count); end
    endcase
  endtask

  task automatic push(input logic v, input logic [31:0] d, input logic [1:0] m, input logic e);
    vec_t x;
    x.v = v; x.data = d; x.mode = m; x.exp = e;
    tab.push_back(x);
  endtask

  // Streams tab[] back-to-back into one instance and checks each result in order.
  task automatic run_stream(input int sel, input string tag);
    int n;
    logic v, r, s;
    logic [1:0] m;
    logic [15:0] c;
    n = tab.size();
    for (int k = 0; k < n + 6; k++) begin
      @(negedge clk);
      if (k >= 5) begin
        int j;
        j = k - 5;
        get_out(sel, v, r, m, s, c);
        if (j < n) begin
          chk($sformatf("%s[%0d].valid", tag, j), 32'(v), 32'(tab[j].v));
          chk($sformatf("%s[%0d].result", tag, j), 32'(r), 32'(tab[j].v & tab[j].exp));
          if (!tab[j].v)
            chk($sformatf("%s[%0d].mode_bubble", tag, j), 32'(m), 32'(0));
          else if (tab[j].mode != 2'b11)
            chk($sformatf("%s[%0d].mode", tag, j), 32'(m), 32'(tab[j].mode));
        end else begin
          chk($sformatf("%s.drain_valid", tag), 32'(v), 32'(0));
        end
      end
      if (k < n) drive(sel, tab[k].v, tab[k].data, tab[k].mode);
      else       drive(sel, 1'b0, 32'h0, 2'b00);
    end
  endtask

  initial begin
    logic v, r, s;
    logic [1:0] m;
    logic [15:0] c;
    int exp_hits;
    int cnt_exp[5];

    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 2'b00);
    ifa.clear = 1'b0; ifb.clear = 1'b0; ifc.clear = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of all three instances.
    for (int i = 0; i < 3; i++) begin
      get_out(i, v, r, m, s, c);
      chk($sformatf("reset[%0d].valid", i), 32'(v), 32'(0));
      chk($sformatf("reset[%0d].result", i), 32'(r), 32'(0));
      chk($sformatf("reset[%0d].mode", i), 32'(m), 32'(0));
      chk($sformatf("reset[%0d].sticky", i), 32'(s), 32'(0));
      chk($sformatf("reset[%0d].count", i), 32'(c), 32'(0));
    end
    rst = 1'b0;

    // Single OR word: checks latency and the one-cycle lag of sticky/count.
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      get_out(0, v, r, m, s, c);
      if (k >= 1 && k <= 4) chk($sformatf("lat.valid_early[%0d]", k), 32'(v), 32'(0));
      if (k == 5) begin
        chk("lat.valid", 32'(v), 32'(1));
        chk("lat.result", 32'(r), 32'(1));
        chk("lat.sticky_not_yet", 32'(s), 32'(0));
        chk("lat.count_not_yet", 32'(c), 32'(0));
      end
      if (k == 6) begin
        chk("lat.valid_after", 32'(v), 32'(0));
        chk("lat.sticky", 32'(s), 32'(1));
        chk("lat.count", 32'(c), 32'(1));
      end
      if (k == 0) drive(0, 1'b1, 32'h0000_0100, 2'b00);
      else        drive(0, 1'b0, 32'h0, 2'b00);
    end

    // Instance a: mixed modes back-to-back, bubbles and mode 11.
    tab.delete();
    push(1, 32'h0000_0100, 2'b00, 1);
    push(1, 32'hFFFF_FFFF, 2'b01, 1);
    push(1, 32'hFFFF_FFFE, 2'b01, 0);
    push(1, 32'h0000_0007, 2'b10, 1);
    push(1, 32'h0000_0003, 2'b10, 0);
    push(0, 32'hFFFF_FFFF, 2'b11, 0);
    push(1, 32'h0000_0001, 2'b11, 1);
    push(0, 32'h0000_0001, 2'b00, 0);
    push(1, 32'h0000_0001, 2'b11, 1);
    push(1, 32'h0000_0000, 2'b00, 0);
    push(1, 32'h0000_0000, 2'b01, 0);
    push(1, 32'h8000_0000, 2'b10, 1);
    push(1, 32'hFFFF_FFFF, 2'b10, 0);
    push(1, 32'h8000_0000, 2'b01, 0);
    exp_hits = 1;
    foreach (tab[i]) if (tab[i].v && tab[i].exp) exp_hits++;
    run_stream(0, "a");
    @(negedge clk);
    get_out(0, v, r, m, s, c);
    chk("a.sticky_end", 32'(s), 32'(1));
    chk("a.count_end", 32'(c), 32'(exp_hits));

    // Clear with no hit in flight zeroes both the flag and the counter.
    ifa.clear = 1'b1;
    @(negedge clk);
    ifa.clear = 1'b0;
    get_out(0, v, r, m, s, c);
    chk("a.clear_sticky", 32'(s), 32'(0));
    chk("a.clear_count", 32'(c), 32'(0));

    // Instance b: WIDTH 20 is padded to 64 bits with the identity of each mode.
    tab.delete();
    push(1, 32'h000F_FFFF, 2'b01, 1);
    push(1, 32'h0000_0000, 2'b00, 0);
    push(1, 32'h0008_0000, 2'b10, 1);
    push(1, 32'h0007_FFFF, 2'b01, 0);
    push(1, 32'h000F_FFFF, 2'b10, 0);
    push(1, 32'h0000_0001, 2'b00, 1);
    run_stream(1, "b");
    @(negedge clk);
    get_out(1, v, r, m, s, c);
    chk("b.count_end", 32'(c), 32'(3));

    // Instance c: 2-bit counter saturates at 3, then clear lands on the sixth hit.
    cnt_exp[0] = 1; cnt_exp[1] = 2; cnt_exp[2] = 3; cnt_exp[3] = 3; cnt_exp[4] = 3;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      get_out(2, v, r, m, s, c);
      if (k >= 6 && k <= 10) chk($sformatf("c.count[%0d]", k - 6), 32'(c), 32'(cnt_exp[k - 6]));
      if (k == 15) chk("c.sixth_valid", 32'(v), 32'(1));
      if (k == 16) begin
        chk("c.clear_hit_count", 32'(c), 32'(1));
        chk("c.clear_hit_sticky", 32'(s), 32'(1));
      end
      if (k <= 4 || k == 10) drive(2, 1'b1, 32'h0000_0001, 2'b00);
      else                   drive(2, 1'b0, 32'h0, 2'b00);
      ifc.clear = (k == 15);
    end

    // Reset one cycle after the last of three words: nothing may emerge afterwards.
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      get_out(0, v, r, m, s, c);
      if (k >= 4) begin
        chk($sformatf("rstmid.valid[%0d]", k), 32'(v), 32'(0));
        chk($sformatf("rstmid.result[%0d]", k), 32'(r), 32'(0));
        chk($sformatf("rstmid.mode[%0d]", k), 32'(m), 32'(0));
      end
      if (k < 3) drive(0, 1'b1, 32'h0000_0001, 2'b00);
      else       drive(0, 1'b0, 32'h0, 2'b00);
      rst = (k == 3);
    end
    get_out(0, v, r, m, s, c);
    chk("rstmid.sticky", 32'(s), 32'(0));
    chk("rstmid.count", 32'(c), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
